// File: rtl/enemy_contact_tx_pkg.sv
// rtl/enemy_contact_tx_pkg.sv - shared constants and FSM state type for enemy contact transmitter
package enemy_contact_tx_pkg;
    localparam int COORD_W = 11;
    localparam int STOMP_MARGIN_DEFAULT = 8;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        EVAL,
        EMIT
    } state_t;
endpackage

// File: rtl/enemy_contact_tx_if.sv
// rtl/enemy_contact_tx_if.sv - position/flag inputs and event outputs of one enemy; optional ENEMY_CONTACT_STATS_EN counters
interface enemy_contact_tx_if #(
    parameter int COORD_W = enemy_contact_tx_pkg::COORD_W
);
    logic               frame_tick;
    logic [COORD_W-1:0] mario_x, mario_y, mario_w, mario_h;
    logic               mario_falling;
    logic [COORD_W-1:0] enemy_x, enemy_y, enemy_w, enemy_h;
    logic               enemy_live;
    logic               enemy_oriental;
    logic               wall_left, wall_right;
    logic               collapsion_impulse;
    logic               press_impulse;
    logic               mario_hurt;
    logic               mario_bounce;
    logic               busy;
`ifdef ENEMY_CONTACT_STATS_EN
    logic [7:0]         stomp_count;
    logic [7:0]         hurt_count;
`endif

    modport master (
        output frame_tick, mario_x, mario_y, mario_w, mario_h, mario_falling,
        output enemy_x, enemy_y, enemy_w, enemy_h, enemy_live, enemy_oriental,
        output wall_left, wall_right,
        input  collapsion_impulse, press_impulse, mario_hurt, mario_bounce, busy
`ifdef ENEMY_CONTACT_STATS_EN
        , input stomp_count, hurt_count
`endif
    );

    modport slave (
        input  frame_tick, mario_x, mario_y, mario_w, mario_h, mario_falling,
        input  enemy_x, enemy_y, enemy_w, enemy_h, enemy_live, enemy_oriental,
        input  wall_left, wall_right,
        output collapsion_impulse, press_impulse, mario_hurt, mario_bounce, busy
`ifdef ENEMY_CONTACT_STATS_EN
        , output stomp_count, hurt_count
`endif
    );
endinterface

// File: rtl/enemy_contact_tx_aabb_overlap.sv
// rtl/enemy_contact_tx_aabb_overlap.sv - combinational axis-aligned box overlap; touching edges do not overlap
module aabb_overlap #(
    parameter int COORD_W = 11
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] aw,
    input  logic [COORD_W-1:0] ah,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] bw,
    input  logic [COORD_W-1:0] bh,
    output logic               overlap
);
    // One extra bit so right/bottom edges near the coordinate limit never wrap
    logic [COORD_W:0] a_right, a_bottom, b_right, b_bottom;

    always_comb begin
        a_right  = {1'b0, ax} + {1'b0, aw};
        a_bottom = {1'b0, ay} + {1'b0, ah};
        b_right  = {1'b0, bx} + {1'b0, bw};
        b_bottom = {1'b0, by} + {1'b0, bh};
        overlap  = ({1'b0, ax} < b_right) && ({1'b0, bx} < a_right) &&
                   ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);
    end
endmodule

// File: rtl/enemy_contact_tx.sv
// rtl/enemy_contact_tx.sv - per-frame Mario/enemy contact evaluator emitting toggle impulses and pulses; ENEMY_CONTACT_STATS_EN adds counters
module enemy_contact_tx #(
    parameter int COORD_W        = enemy_contact_tx_pkg::COORD_W,
    parameter int STOMP_MARGIN   = enemy_contact_tx_pkg::STOMP_MARGIN_DEFAULT,
    parameter int COOLDOWN_TICKS = 25000000
) (
    input  logic             clk,
    input  logic             rstn,
    enemy_contact_tx_if.slave bus
);
    import enemy_contact_tx_pkg::*;

    localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);

    state_t state, state_next;

    logic [COORD_W-1:0] s_mx, s_my, s_mw, s_mh, s_ex, s_ey, s_ew, s_eh;
    logic               s_falling, s_live, s_ori, s_wall_left, s_wall_right;
    logic               ovl_comb, stomp_raw, stomp_comb, side_comb, wall_comb;
    logic [COORD_W:0]   mario_bottom, stomp_limit;
    logic               r_stomp, r_side, r_wall_hit;
    logic [CD_W-1:0]    cooldown;
    logic               wall_armed;
    logic               collapse_q, press_q, hurt_q, bounce_q;
`ifdef ENEMY_CONTACT_STATS_EN
    logic [7:0]         stomp_cnt_q, hurt_cnt_q;
`endif

    aabb_overlap #(.COORD_W(COORD_W)) u_overlap (
        .ax(s_mx), .ay(s_my), .aw(s_mw), .ah(s_mh),
        .bx(s_ex), .by(s_ey), .bw(s_ew), .bh(s_eh),
        .overlap(ovl_comb)
    );

    always_comb begin
        mario_bottom = {1'b0, s_my} + {1'b0, s_mh};
        stomp_limit  = {1'b0, s_ey} + (COORD_W+1)'(STOMP_MARGIN);
        stomp_raw    = ovl_comb && s_live && s_falling && (mario_bottom <= stomp_limit);
        stomp_comb   = stomp_raw && (cooldown == '0);
        side_comb    = ovl_comb && s_live && !stomp_raw && (cooldown == '0);
        wall_comb    = (s_ori == DIR_LEFT) ? s_wall_left : s_wall_right;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Ticks outside IDLE are dropped: only IDLE looks at frame_tick
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.frame_tick) state_next = SNAP;
            SNAP:    state_next = EVAL;
            EVAL:    state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            collapse_q <= 1'b0;
            press_q    <= 1'b0;
            hurt_q     <= 1'b0;
            bounce_q   <= 1'b0;
            cooldown   <= '0;
            wall_armed <= 1'b1;
            r_stomp    <= 1'b0;
            r_side     <= 1'b0;
            r_wall_hit <= 1'b0;
`ifdef ENEMY_CONTACT_STATS_EN
            stomp_cnt_q <= 8'd0;
            hurt_cnt_q  <= 8'd0;
`endif
        end else begin
            hurt_q   <= 1'b0;
            bounce_q <= 1'b0;
            if (cooldown != '0) cooldown <= cooldown - CD_W'(1);
            case (state)
                SNAP: begin
                    s_mx <= bus.mario_x;  s_my <= bus.mario_y;
                    s_mw <= bus.mario_w;  s_mh <= bus.mario_h;
                    s_ex <= bus.enemy_x;  s_ey <= bus.enemy_y;
                    s_ew <= bus.enemy_w;  s_eh <= bus.enemy_h;
                    s_falling    <= bus.mario_falling;
                    s_live       <= bus.enemy_live;
                    s_ori        <= bus.enemy_oriental;
                    s_wall_left  <= bus.wall_left;
                    s_wall_right <= bus.wall_right;
                end
                EVAL: begin
                    r_stomp    <= stomp_comb;
                    r_side     <= side_comb;
                    r_wall_hit <= wall_comb;
                end
                EMIT: begin
                    if (r_stomp) begin
                        press_q  <= ~press_q;
                        bounce_q <= 1'b1;
                        cooldown <= CD_W'(COOLDOWN_TICKS);
`ifdef ENEMY_CONTACT_STATS_EN
                        if (stomp_cnt_q != 8'hFF) stomp_cnt_q <= stomp_cnt_q + 8'd1;
`endif
                    end else if (r_side) begin
                        hurt_q   <= 1'b1;
                        cooldown <= CD_W'(COOLDOWN_TICKS);
`ifdef ENEMY_CONTACT_STATS_EN
                        if (hurt_cnt_q != 8'hFF) hurt_cnt_q <= hurt_cnt_q + 8'd1;
`endif
                    end
                    // Disarm after one flip so the lagging direction update cannot cause a second reversal
                    if (r_wall_hit && wall_armed) begin
                        collapse_q <= ~collapse_q;
                        wall_armed <= 1'b0;
                    end else if (!r_wall_hit) begin
                        wall_armed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.collapsion_impulse = collapse_q;
    assign bus.press_impulse      = press_q;
    assign bus.mario_hurt         = hurt_q;
    assign bus.mario_bounce       = bounce_q;
    assign bus.busy               = (state != IDLE);
`ifdef ENEMY_CONTACT_STATS_EN
    assign bus.stomp_count        = stomp_cnt_q;
    assign bus.hurt_count         = hurt_cnt_q;
`endif
endmodule
